// File: rtl/reg_file_pkg.sv
// Shared types and init-value helper for the parametrised register file.
// Optional write-to-read forwarding is selected in the top by REG_FILE_BYPASS_EN.
package reg_file_pkg;

  typedef enum logic {INIT, RUN} rf_state_t;

  localparam logic [1:0] INIT_ZERO  = 2'd0;
  localparam logic [1:0] INIT_INDEX = 2'd1;
  localparam logic [1:0] INIT_BCD   = 2'd2;

  // Result is wide enough for any index; callers size it to their data width.
  localparam int INIT_VAL_W = 64;

  function automatic logic [INIT_VAL_W-1:0] init_value(input logic [6:0] idx,
                                                       input logic [1:0] mode);
    logic [INIT_VAL_W-1:0] val;
    val = '0;
    case (mode)
      INIT_INDEX: val = INIT_VAL_W'(idx);
      INIT_BCD: begin
        val[7:4] = 4'(idx / 7'd10);
        val[3:0] = 4'(idx % 7'd10);
      end
      default: val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/reg_file_init_seq.sv
// Post-reset initialisation sequencer: walks entries 1..DEPTH-1 once, then
// parks in RUN with ready asserted until the next reset.
module reg_file_init_seq
  import reg_file_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic              ready
);

  rf_state_t         state_reg;
  logic [ADDR_W-1:0] init_ptr_reg;
  logic              ready_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= INIT;
      init_ptr_reg <= ADDR_W'(1);
      ready_reg    <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          // Pointer holds at the last entry rather than wrapping.
          if (init_ptr_reg == ADDR_W'(DEPTH - 1)) begin
            state_reg <= RUN;
            ready_reg <= 1'b1;
          end else begin
            init_ptr_reg <= init_ptr_reg + ADDR_W'(1);
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign init_we   = (state_reg == INIT) && !reset;
  assign init_addr = init_ptr_reg;
  assign ready     = ready_reg;

endmodule

// File: rtl/param_reg_file.sv
// Parametrised 2-read/1-write register file, entry 0 hardwired to zero.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
module param_reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int INIT_MODE = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg_num1,
  input  logic [ADDR_W-1:0] read_reg_num2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic              ready
);

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;

  reg_file_init_seq #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_init_seq (
    .clock    (clock),
    .reset    (reset),
    .init_we  (init_we),
    .init_addr(init_addr),
    .ready    (ready)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // The sequencer owns the write port until ready; core writes are dropped then.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = write_reg;
    wr_data = write_data;
    if (init_we) begin
      wr_en   = 1'b1;
      wr_addr = init_addr;
      wr_data = DATA_W'(init_value(7'(init_addr), 2'(INIT_MODE)));
    end else if (ready && regwrite && (write_reg != '0)) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = (gi == 0) ? read_reg_num1 : read_reg_num2;

    always_comb begin
      data = mem[addr];
`ifdef REG_FILE_BYPASS_EN
      if (regwrite && (write_reg != '0) && (write_reg == addr)) begin
        data = write_data;
      end
`endif
      // Entry 0 is never written, so it is masked here rather than stored.
      if (!ready || (addr == '0)) begin
        data = '0;
      end
    end
  end

  assign read_data1 = g_rd[0].data;
  assign read_data2 = g_rd[1].data;

endmodule

// File: tb/tb_param_reg_file.sv
// Randomised self-checking bench for param_reg_file: a 32x32 BCD-init instance
// and an 8x16 index-init instance, compared against an array-based model.
module tb_param_reg_file;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_a, we_a, ready_a;
  logic [4:0]  rr1_a, rr2_a, wreg_a;
  logic [31:0] rd1_a, rd2_a, wdata_a;

  logic        reset_b, we_b, ready_b;
  logic [2:0]  rr1_b, rr2_b, wreg_b;
  logic [15:0] rd1_b, rd2_b, wdata_b;

  param_reg_file #(.DATA_W(32), .DEPTH(32), .INIT_MODE(2)) dut_a (
    .clock(clock), .reset(reset_a),
    .read_reg_num1(rr1_a), .read_reg_num2(rr2_a),
    .read_data1(rd1_a), .read_data2(rd2_a),
    .regwrite(we_a), .write_reg(wreg_a), .write_data(wdata_a),
    .ready(ready_a)
  );

  param_reg_file #(.DATA_W(16), .DEPTH(8), .INIT_MODE(1)) dut_b (
    .clock(clock), .reset(reset_b),
    .read_reg_num1(rr1_b), .read_reg_num2(rr2_b),
    .read_data1(rd1_b), .read_data2(rd2_b),
    .regwrite(we_b), .write_reg(wreg_b), .write_data(wdata_b),
    .ready(ready_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_a [32];
  logic        exp_ready_a = 1'b0;
  int          init_cnt_a  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bcd(input int i);
    return 32'((i / 10) * 16 + (i % 10));
  endfunction

  function automatic logic [31:0] exp_a(input logic [4:0] a);
    if (!exp_ready_a) return 32'd0;
`ifdef REG_FILE_BYPASS_EN
    if (we_a && wreg_a != 5'd0 && wreg_a == a) return wdata_a;
`endif
    if (a == 5'd0) return 32'd0;
    return model_a[a];
  endfunction

  // Advance one clock for instance A and apply the edge to the model.
  task automatic tick_a();
    logic rst, we;
    logic [4:0] wr;
    logic [31:0] wd;
    rst = reset_a; we = we_a; wr = wreg_a; wd = wdata_a;
    @(posedge clock);
    if (rst) begin
      exp_ready_a = 1'b0;
      init_cnt_a  = 0;
      for (int i = 0; i < 32; i++) model_a[i] = bcd(i);
    end else begin
      if (exp_ready_a && we && wr != 5'd0) model_a[wr] = wd;
      if (!exp_ready_a) begin
        init_cnt_a++;
        if (init_cnt_a == 31) exp_ready_a = 1'b1;
      end
    end
    #1;
  endtask

  task automatic tick_b();
    @(posedge clock);
    #1;
  endtask

  task automatic check_ports_a(input string tag);
    #1;
    check({tag, ".rd1"}, rd1_a, exp_a(rr1_a));
    check({tag, ".rd2"}, rd2_a, exp_a(rr2_a));
    check({tag, ".ready"}, {31'd0, ready_a}, {31'd0, exp_ready_a});
  endtask

  initial begin
    logic [31:0] exp_byp;
    logic [15:0] vb;
    reset_a = 1'b1; we_a = 1'b0; wreg_a = '0; wdata_a = '0; rr1_a = '0; rr2_a = '0;
    reset_b = 1'b1; we_b = 1'b0; wreg_b = '0; wdata_b = '0; rr1_b = '0; rr2_b = '0;

    // Reset, then INIT with reads forced to 0 and a dropped write to reg 3.
    tick_a();
    reset_a = 1'b0;
    for (int n = 0; n < 31; n++) begin
      rr1_a = 5'($urandom); rr2_a = 5'($urandom);
      we_a = (n == 12); wreg_a = 5'd3; wdata_a = 32'hFFFF;
      #1;
      check("init_rd1", rd1_a, 32'd0);
      check("init_rd2", rd2_a, 32'd0);
      check("init_ready", {31'd0, ready_a}, 32'd0);
      tick_a();
    end
    we_a = 1'b0;
    check("ready_up", {31'd0, ready_a}, 32'd1);

    rr1_a = 5'd10; rr2_a = 5'd31; #1;
    check("bcd_r10", rd1_a, 32'h10);
    check("bcd_r31", rd2_a, 32'h31);
    rr1_a = 5'd0; rr2_a = 5'd3; #1;
    check("r0_zero", rd1_a, 32'd0);
    check("r3_init_kept", rd2_a, 32'h3);

    // Write then read back; write to reg 0 is ignored.
    rr1_a = 5'd0; rr2_a = 5'd0;
    we_a = 1'b1; wreg_a = 5'd5; wdata_a = 32'hDEADBEEF;
    tick_a();
    we_a = 1'b0; rr1_a = 5'd5; #1;
    check("wr_r5", rd1_a, 32'hDEADBEEF);
    we_a = 1'b1; wreg_a = 5'd0; wdata_a = 32'h1234; rr1_a = 5'd1;
    tick_a();
    we_a = 1'b0; rr1_a = 5'd0; rr2_a = 5'd5; #1;
    check("wr_r0_ignored", rd1_a, 32'd0);
    check("r5_kept", rd2_a, 32'hDEADBEEF);

    // Same-cycle write/read of reg 7 on both ports.
`ifdef REG_FILE_BYPASS_EN
    exp_byp = 32'hA5A5;
`else
    exp_byp = 32'h7;
`endif
    we_a = 1'b1; wreg_a = 5'd7; wdata_a = 32'hA5A5; rr1_a = 5'd7; rr2_a = 5'd7; #1;
    check("same_cyc_rd1", rd1_a, exp_byp);
    check("same_cyc_rd2", rd2_a, exp_byp);
    tick_a();
    we_a = 1'b0; #1;
    check("next_cyc_rd1", rd1_a, 32'hA5A5);
    check("next_cyc_rd2", rd2_a, 32'hA5A5);

    // Reset again, then re-reset 10 cycles into INIT: full count restarts.
    reset_a = 1'b1;
    tick_a();
    reset_a = 1'b0;
    for (int n = 0; n < 10; n++) begin
      check("init1_ready", {31'd0, ready_a}, 32'd0);
      tick_a();
    end
    reset_a = 1'b1;
    tick_a();
    reset_a = 1'b0;
    for (int n = 0; n < 31; n++) begin
      check("restart_ready", {31'd0, ready_a}, 32'd0);
      tick_a();
    end
    check("restart_ready_up", {31'd0, ready_a}, 32'd1);
    for (int i = 0; i < 32; i += 2) begin
      rr1_a = 5'(i); rr2_a = 5'(i + 1); #1;
      check("reinit_even", rd1_a, (i == 0) ? 32'd0 : bcd(i));
      check("reinit_odd", rd2_a, bcd(i + 1));
    end

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      reset_a = ($urandom_range(0, 79) == 0);
      rr1_a = 5'($urandom); rr2_a = 5'($urandom);
      we_a = 1'($urandom_range(0, 1));
      wreg_a = ($urandom_range(0, 3) == 0) ? rr1_a : 5'($urandom);
      wdata_a = $urandom;
      check_ports_a("rand");
      tick_a();
    end
    reset_a = 1'b0; we_a = 1'b0;

    // Small instance: DEPTH 8, DATA_W 16, index init.
    tick_b();
    reset_b = 1'b0;
    for (int n = 0; n < 7; n++) begin
      check("b_init_ready", {31'd0, ready_b}, 32'd0);
      tick_b();
    end
    check("b_ready_up", {31'd0, ready_b}, 32'd1);
    for (int i = 0; i < 8; i += 2) begin
      rr1_b = 3'(i); rr2_b = 3'(i + 1); #1;
      check("b_idx_even", {16'd0, rd1_b}, 32'(i));
      check("b_idx_odd", {16'd0, rd2_b}, 32'(i + 1));
    end
    rr1_b = 3'd6; #1;
    check("b_r6", {16'd0, rd1_b}, 32'h0006);
    vb = 16'($urandom_range(8, 16'hFFFF));
    rr1_b = 3'd0; rr2_b = 3'd0;
    we_b = 1'b1; wreg_b = 3'd7; wdata_b = vb;
    tick_b();
    we_b = 1'b0; rr1_b = 3'd7; rr2_b = 3'd6; #1;
    check("b_wr_r7", {16'd0, rd1_b}, {16'd0, vb});
    check("b_r6_kept", {16'd0, rd2_b}, 32'h0006);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
